// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: credit-metered requests to a 1-cycle ROM, prefetch FIFO
// toward decode, and epoch-tagged squashing of in-flight words on PC redirect.
module fetch_ctrl #(
    parameter int                 WIDTH      = 32,
    parameter logic [WIDTH-1:0]   RESET_PC   = '0,
    parameter int                 FIFO_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    output logic             mem_req,
    output logic [WIDTH-1:0] mem_addr,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    input  logic             halt,
    output logic             instr_valid,
    output logic [WIDTH-1:0] instr_out,
    output logic [WIDTH-1:0] instr_pc,
    input  logic             instr_ready
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_HALT} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
    logic               epoch_q, epoch_d;
    logic               infl_q, infl_d;
    logic               infl_epoch_q, infl_epoch_d;
    logic [WIDTH-1:0]   infl_pc_q, infl_pc_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      occ_q, occ_d;
    logic [WIDTH-1:0]   fifo_instr_q [FIFO_DEPTH];
    logic [WIDTH-1:0]   fifo_instr_d [FIFO_DEPTH];
    logic [WIDTH-1:0]   fifo_pc_q    [FIFO_DEPTH];
    logic [WIDTH-1:0]   fifo_pc_d    [FIFO_DEPTH];

    logic               pop;
    logic               wr_en;
    logic               can_issue;
    logic [CW-1:0]      credit_used;

    assign instr_valid = (occ_q != '0);
    assign instr_out   = fifo_instr_q[rd_ptr_q];
    assign instr_pc    = fifo_pc_q[rd_ptr_q];
    assign pop         = instr_valid & instr_ready;
    // A word returning from a request issued before the last redirect carries a stale epoch.
    assign wr_en       = infl_q & (infl_epoch_q == epoch_q);
    assign credit_used = occ_q + CW'(infl_q) - CW'(pop);
    assign can_issue   = (state_q == ST_RUN) & ~halt & (credit_used < CW'(FIFO_DEPTH));
    assign mem_req     = can_issue & ~redirect_valid;
    assign mem_addr    = fetch_pc_q;

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        epoch_d      = epoch_q;
        infl_d       = mem_req;
        infl_epoch_d = epoch_q;
        infl_pc_d    = fetch_pc_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        occ_d        = occ_q + CW'(wr_en) - CW'(pop);
        fifo_instr_d = fifo_instr_q;
        fifo_pc_d    = fifo_pc_q;

        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN:  if (halt)  state_d = ST_HALT;
            ST_HALT: if (!halt) state_d = ST_RUN;
            default: state_d = ST_BOOT;
        endcase

        if (mem_req)
            fetch_pc_d = fetch_pc_q + WIDTH'(4);
        if (wr_en) begin
            fifo_instr_d[wr_ptr_q] = mem_rdata;
            fifo_pc_d[wr_ptr_q]    = infl_pc_q;
            wr_ptr_d               = wr_ptr_q + PW'(1);
        end
        if (pop)
            rd_ptr_d = rd_ptr_q + PW'(1);

        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & ~WIDTH'(3);
            epoch_d    = ~epoch_q;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            occ_d      = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_BOOT;
            fetch_pc_q   <= RESET_PC;
            epoch_q      <= 1'b0;
            infl_q       <= 1'b0;
            infl_epoch_q <= 1'b0;
            infl_pc_q    <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            occ_q        <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_instr_q[i] <= '0;
                fifo_pc_q[i]    <= '0;
            end
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            epoch_q      <= epoch_d;
            infl_q       <= infl_d;
            infl_epoch_q <= infl_epoch_d;
            infl_pc_q    <= infl_pc_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            occ_q        <= occ_d;
            fifo_instr_q <= fifo_instr_d;
            fifo_pc_q    <= fifo_pc_d;
        end
    end

    // The credit check makes a write into a full FIFO without a pop unreachable.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(wr_en && !pop && !redirect_valid && occ_q == CW'(FIFO_DEPTH)));

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomized and directed bench for fetch_ctrl; a stream-level scoreboard tracks which
// PCs must be requested and delivered, independent of the FIFO/credit implementation.
module tb_fetch_ctrl;
    localparam int          W   = 32;
    localparam int          D   = 2;
    localparam logic [31:0] RPC = 32'h0;

    logic          clk, rst;
    logic          mem_req;
    logic [W-1:0]  mem_addr, mem_rdata;
    logic          redirect_valid;
    logic [W-1:0]  redirect_pc;
    logic          halt;
    logic          instr_valid;
    logic [W-1:0]  instr_out, instr_pc;
    logic          instr_ready;

    fetch_ctrl #(.WIDTH(W), .RESET_PC(RPC), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
        .instr_valid(instr_valid), .instr_out(instr_out), .instr_pc(instr_pc),
        .instr_ready(instr_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return {2'b00, a[31:2]};
    endfunction

    // Synchronous ROM: garbage when not requested so a spurious capture shows up.
    always @(posedge clk) mem_rdata <= mem_req ? rom(mem_addr) : $urandom;

    int          errors = 0;
    int          checks = 0;
    int          pops   = 0;
    logic [31:0] exp_fetch, exp_pop;
    logic        prev_stall;
    logic [31:0] prev_out, prev_pc;

    task automatic sb_reset();
        exp_fetch  = RPC;
        exp_pop    = RPC;
        prev_stall = 1'b0;
    endtask

    // Called mid-cycle: checks the stream rules for this cycle, then advances to posedge+1.
    task automatic fin();
        if (prev_stall) begin
            checks++;
            if (instr_valid !== 1'b1 || instr_out !== prev_out || instr_pc !== prev_pc) begin
                errors++;
                $display("FAIL head_stable: got v=%0b out=%h pc=%h, want v=1 out=%h pc=%h",
                         instr_valid, instr_out, instr_pc, prev_out, prev_pc);
            end
        end
        if (mem_req === 1'b1) begin
            checks++;
            if (mem_addr !== exp_fetch) begin
                errors++;
                $display("FAIL req_addr: got %h, want %h", mem_addr, exp_fetch);
            end
            checks++;
            if (halt || redirect_valid) begin
                errors++;
                $display("FAIL req_blocked: got mem_req=1 with halt=%0b redirect=%0b, want 0",
                         halt, redirect_valid);
            end
            exp_fetch += 32'd4;
        end
        if (instr_valid === 1'b1 && instr_ready) begin
            checks++;
            if (instr_pc !== exp_pop || instr_out !== rom(exp_pop)) begin
                errors++;
                $display("FAIL deliver: got pc=%h out=%h, want pc=%h out=%h",
                         instr_pc, instr_out, exp_pop, rom(exp_pop));
            end
            exp_pop += 32'd4;
            pops++;
        end
        prev_stall = (instr_valid === 1'b1) && !instr_ready && !redirect_valid;
        prev_out   = instr_out;
        prev_pc    = instr_pc;
        if (redirect_valid) begin
            exp_fetch = {redirect_pc[31:2], 2'b00};
            exp_pop   = exp_fetch;
        end
        checks++;
        if ((exp_fetch - exp_pop) > 32'(4 * D)) begin
            errors++;
            $display("FAIL credit: got %0d outstanding, want <= %0d", (exp_fetch - exp_pop) >> 2, D);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        @(negedge clk);
        fin();
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (mem_req !== 1'b0 || mem_addr !== RPC || instr_valid !== 1'b0 ||
            instr_out !== '0 || instr_pc !== '0) begin
            errors++;
            $display("FAIL %s: got req=%0b addr=%h v=%0b out=%h pc=%h, want 0 %h 0 0 0",
                     tag, mem_req, mem_addr, instr_valid, instr_out, instr_pc, RPC);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; instr_ready = 1'b1; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset_state");
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb_reset();
    endtask

    // Cycle 0 is the first cycle after reset release.
    task automatic test_startup();
        instr_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0) begin errors++; $display("FAIL boot_noreq: got %0b, want 0", mem_req); end
        fin();
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== RPC || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL first_req: got req=%0b addr=%h v=%0b, want 1 %h 0", mem_req, mem_addr, instr_valid, RPC);
        end
        fin();
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== RPC + 32'd4 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL second_req: got req=%0b addr=%h v=%0b, want 1 %h 0", mem_req, mem_addr, instr_valid, RPC + 32'd4);
        end
        fin();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (instr_valid !== 1'b1 || instr_out !== rom(RPC + 32'(4 * k))) begin
                errors++;
                $display("FAIL startup_stream%0d: got v=%0b out=%h, want 1 %h", k, instr_valid, instr_out, rom(RPC + 32'(4 * k)));
            end
            fin();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] h_pc;
        int          p0;
        instr_ready = 1'b0;
        h_pc = '0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 0) h_pc = instr_pc;
            if (k == 4) begin
                checks++;
                if (mem_req !== 1'b0 || instr_valid !== 1'b1 || instr_pc !== h_pc) begin
                    errors++;
                    $display("FAIL stall_hold: got req=%0b v=%0b pc=%h, want 0 1 %h", mem_req, instr_valid, instr_pc, h_pc);
                end
                checks++;
                if ((exp_fetch - exp_pop) !== 32'(4 * D)) begin
                    errors++;
                    $display("FAIL stall_fill: got %0d buffered, want %0d", (exp_fetch - exp_pop) >> 2, D);
                end
            end
            fin();
        end
        instr_ready = 1'b1;
        p0 = pops;
        repeat (6) step();
        checks++;
        if (pops - p0 !== 6) begin
            errors++;
            $display("FAIL resume_rate: got %0d pops in 6 cycles, want 6", pops - p0);
        end
    endtask

    task automatic do_redirect(input logic [31:0] pc, input string tag);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0) begin errors++; $display("FAIL %s_noreq: got %0b, want 0", tag, mem_req); end
        fin();
        redirect_valid = 1'b0;
        redirect_pc    = $urandom;
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== {pc[31:2], 2'b00}) begin
            errors++;
            $display("FAIL %s_r1: got v=%0b req=%0b addr=%h, want 0 1 %h", tag, instr_valid, mem_req, mem_addr, {pc[31:2], 2'b00});
        end
        fin();
    endtask

    task automatic test_redirect();
        instr_ready = 1'b1;
        repeat (3) step();
        do_redirect(32'h103, "redir");
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b0) begin errors++; $display("FAIL redir_r2: got v=%0b, want 0", instr_valid); end
        fin();
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instr_out !== rom(32'h100)) begin
            errors++;
            $display("FAIL redir_r3: got v=%0b pc=%h out=%h, want 1 00000100 %h", instr_valid, instr_pc, instr_out, rom(32'h100));
        end
        fin();
        repeat (3) step();
    endtask

    task automatic test_halt();
        logic [31:0] resume;
        instr_ready = 1'b1;
        resume = exp_fetch;
        halt = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (mem_req !== 1'b0) begin errors++; $display("FAIL halt_noreq%0d: got %0b, want 0", k, mem_req); end
            if (k == 3) begin
                checks++;
                if (instr_valid !== 1'b0) begin errors++; $display("FAIL halt_drain: got v=%0b, want 0", instr_valid); end
            end
            fin();
        end
        halt = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0) begin errors++; $display("FAIL unhalt_bubble: got %0b, want 0", mem_req); end
        fin();
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== resume) begin
            errors++;
            $display("FAIL unhalt_resume: got req=%0b addr=%h, want 1 %h", mem_req, mem_addr, resume);
        end
        fin();
        repeat (3) step();
    endtask

    task automatic test_wrap();
        instr_ready = 1'b1;
        do_redirect(32'hFFFF_FFFC, "wrap");
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
            errors++;
            $display("FAIL wrap_addr: got req=%0b addr=%h, want 1 00000000", mem_req, mem_addr);
        end
        fin();
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_pc0: got v=%0b pc=%h, want 1 fffffffc", instr_valid, instr_pc);
        end
        fin();
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
            errors++;
            $display("FAIL wrap_pc1: got v=%0b pc=%h, want 1 00000000", instr_valid, instr_pc);
        end
        fin();
        repeat (2) step();
    endtask

    task automatic test_reset_midop();
        instr_ready = 1'b1;
        repeat (2) step();
        instr_ready = 1'b0;
        step();
        instr_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b1 || mem_req !== 1'b1) begin
            errors++;
            $display("FAIL midop_setup: got v=%0b req=%0b, want 1 1", instr_valid, mem_req);
        end
        rst = 1'b1;
        #1;
        check_reset_outputs("midop_async");
        sb_reset();
        @(posedge clk);
        #1;
        check_reset_outputs("midop_held");
        rst = 1'b0;
        test_startup();
    endtask

    task automatic test_random();
        int p0;
        p0 = pops;
        for (int c = 0; c < 400; c++) begin
            instr_ready    = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) halt = ~halt;
            redirect_valid = ($urandom_range(0, 24) == 0);
            redirect_pc    = $urandom;
            step();
        end
        halt = 1'b0; redirect_valid = 1'b0; instr_ready = 1'b1;
        repeat (6) step();
        checks++;
        if (pops - p0 < 60) begin
            errors++;
            $display("FAIL random_progress: got %0d pops, want >= 60", pops - p0);
        end
        checks++;
        if (instr_valid !== 1'b1) begin errors++; $display("FAIL random_flow: got v=%0b, want 1", instr_valid); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_startup();
        test_backpressure();
        test_redirect();
        test_halt();
        test_wrap();
        test_reset_midop();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
